// File: rtl/tmds_decoder_channel.sv
// One-lane TMDS receiver: word alignment on DVI control tokens, then
// token / pixel decode. Three-stage pipeline: capture, window select, decode.
module tmds_decoder_channel #(
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_RUN       = 8,
  parameter int LOSS_TIMEOUT   = 2048
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int RUN_W  = (LOCK_RUN > 1)       ? $clog2(LOCK_RUN)       : 1;
  localparam int LOSS_W = (LOSS_TIMEOUT > 1)   ? $clog2(LOSS_TIMEOUT)   : 1;

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_RUN - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [9:0]        w_cur_reg;
  logic [9:0]        w_prev_reg;
  logic [9:0]        win_reg;
  logic [19:0]       pair_shift;
  logic [1:0]        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [RUN_W-1:0]  run_reg, run_next;
  logic [LOSS_W-1:0] loss_reg, loss_next;
  logic [3:0]        offset_reg, offset_next;
  logic              locked_reg, locked_next;
  logic [7:0]        data_reg;
  logic [1:0]        ctrl_reg;
  logic              de_reg;
  logic              is_tok;
  logic [1:0]        tok_code;
  logic [7:0]        dec_byte;

  // Undo the TMDS XOR/XNOR chain and optional inversion of the low byte.
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o    = 8'h00;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  // Two consecutive words side by side; older word occupies the low bits
  // because bit 0 is first on the wire.
  assign pair_shift = {w_cur_reg, w_prev_reg} >> offset_reg;
  assign dec_byte   = tmds_decode(win_reg);

  // Capture raw words and select the 10-bit window at the current offset.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      w_cur_reg  <= '0;
      w_prev_reg <= '0;
      win_reg    <= '0;
    end else begin
      w_cur_reg  <= tmds_word;
      w_prev_reg <= w_cur_reg;
      win_reg    <= pair_shift[9:0];
    end
  end

  // Recognise the four control tokens in the aligned window.
  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (win_reg)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
  end

  // Alignment FSM: hunt offsets, confirm a token run, watch for token loss.
  always_comb begin
    state_next  = state_reg;
    tmo_next    = tmo_reg;
    run_next    = run_reg;
    loss_next   = loss_reg;
    offset_next = offset_reg;
    locked_next = locked_reg;
    case (state_reg)
      ST_SEARCH: begin
        if (is_tok) begin
          state_next = ST_VERIFY;
          run_next   = RUN_W'(1);
          tmo_next   = '0;
        end else if (tmo_reg == TMO_LAST) begin
          offset_next = (offset_reg == 4'd9) ? 4'd0 : 4'(offset_reg + 4'd1);
          tmo_next    = '0;
        end else if (tmo_reg != '1) begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      ST_VERIFY: begin
        if (is_tok) begin
          if (run_reg == RUN_LAST) begin
            state_next  = ST_LOCKED;
            locked_next = 1'b1;
            run_next    = '0;
            loss_next   = '0;
          end else if (run_reg != '1) begin
            run_next = run_reg + 1'b1;
          end
        end else begin
          state_next = ST_SEARCH;
          run_next   = '0;
          tmo_next   = '0;
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          loss_next = '0;
        end else if (loss_reg == LOSS_LAST) begin
          state_next  = ST_SEARCH;
          locked_next = 1'b0;
          loss_next   = '0;
          run_next    = '0;
          tmo_next    = '0;
        end else if (loss_reg != '1) begin
          loss_next = loss_reg + 1'b1;
        end
      end
      default: begin
        state_next  = ST_SEARCH;
        locked_next = 1'b0;
        tmo_next    = '0;
        run_next    = '0;
        loss_next   = '0;
      end
    endcase
  end

  // FSM state, counters and alignment offset.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_SEARCH;
      tmo_reg    <= '0;
      run_reg    <= '0;
      loss_reg   <= '0;
      offset_reg <= '0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tmo_reg    <= tmo_next;
      run_reg    <= run_next;
      loss_reg   <= loss_next;
      offset_reg <= offset_next;
      locked_reg <= locked_next;
    end
  end

  // Decoded outputs follow the lock flag of the same edge, so de/ctrl/data
  // never disagree with the locked output.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      ctrl_reg <= '0;
      de_reg   <= 1'b0;
    end else if (locked_next) begin
      if (is_tok) begin
        de_reg   <= 1'b0;
        ctrl_reg <= tok_code;
      end else begin
        de_reg   <= 1'b1;
        data_reg <= dec_byte;
      end
    end else begin
      de_reg   <= 1'b0;
      ctrl_reg <= 2'b00;
      data_reg <= 8'h00;
    end
  end

  assign data       = data_reg;
  assign ctrl       = ctrl_reg;
  assign de         = de_reg;
  assign locked     = locked_reg;
  assign bit_offset = offset_reg;

endmodule

// File: tb/tb_tmds_decoder_channel.sv
// Bench for tmds_decoder_channel: directed scenarios plus random words, each
// cycle compared against a bit-stream reference model of the lane receiver.
module tb_tmds_decoder_channel;

  localparam int SEARCH_TIMEOUT = 1024;
  localparam int LOCK_RUN       = 8;
  localparam int LOSS_TIMEOUT   = 2048;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] WA  = 10'b0100000000;
  localparam logic [9:0] WB  = 10'b1011111111;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic [9:0] tmds_word = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;

  int errors = 0;
  int checks = 0;
  string phase = "init";

  // Reference model state: the last 20 wire bits (oldest first), the
  // window under inspection, alignment bookkeeping and expected outputs.
  bit         m_bits[$];
  logic [9:0] m_win;
  int         m_off, m_idle, m_run, m_loss;
  bit         m_locked;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  bit         m_de;

  tmds_decoder_channel #(
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOCK_RUN(LOCK_RUN),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .pixclk(pixclk),
    .rst_n(rst_n),
    .tmds_word(tmds_word),
    .data(data),
    .ctrl(ctrl),
    .de(de),
    .locked(locked),
    .bit_offset(bit_offset)
  );

  always #5 pixclk = ~pixclk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int tok_lookup(input logic [9:0] w);
    case (w)
      T00:     return 0;
      T01:     return 1;
      T10:     return 2;
      T11:     return 3;
      default: return -1;
    endcase
  endfunction

  // Inverse of the encoder: strip inversion, then each bit is the
  // difference of neighbours, complemented when q[8] says XNOR was used.
  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] x;
    d = q[9] ? ~q[7:0] : q[7:0];
    x = d ^ (d << 1);
    if (!q[8]) x = x ^ 8'hFE;
    return x;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    for (int i = 0; i < 20; i++) m_bits.push_back(1'b0);
    m_win = '0; m_off = 0; m_idle = 0; m_run = 0; m_loss = 0;
    m_locked = 1'b0; m_data = '0; m_ctrl = '0; m_de = 1'b0;
  endtask

  // Expected state after the next rising edge when word w is on the input.
  task automatic model_step(input logic [9:0] w);
    int code;
    int old_off;
    logic [9:0] nw;
    code    = tok_lookup(m_win);
    old_off = m_off;
    if (m_locked) begin
      if (code >= 0) m_loss = 0;
      else begin
        m_loss++;
        if (m_loss == LOSS_TIMEOUT) begin
          m_locked = 1'b0; m_loss = 0; m_run = 0; m_idle = 0;
        end
      end
    end else if (m_run > 0) begin
      if (code >= 0) begin
        m_run++;
        if (m_run == LOCK_RUN) begin
          m_locked = 1'b1; m_run = 0; m_loss = 0;
        end
      end else begin
        m_run = 0; m_idle = 0;
      end
    end else begin
      if (code >= 0) begin
        m_run = 1; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == SEARCH_TIMEOUT) begin
          m_off = (m_off + 1) % 10; m_idle = 0;
        end
      end
    end
    if (m_locked) begin
      if (code >= 0) begin
        m_de = 1'b0; m_ctrl = 2'(code);
      end else begin
        m_de = 1'b1; m_data = ref_decode(m_win);
      end
    end else begin
      m_de = 1'b0; m_ctrl = 2'b00; m_data = 8'h00;
    end
    for (int i = 0; i < 10; i++) nw[i] = m_bits[old_off + i];
    m_win = nw;
    for (int i = 0; i < 10; i++) m_bits.push_back(w[i]);
    for (int i = 0; i < 10; i++) void'(m_bits.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("data",       32'(data),       32'(m_data));
    check("ctrl",       32'(ctrl),       32'(m_ctrl));
    check("de",         32'(de),         32'(m_de));
    check("locked",     32'(locked),     32'(m_locked));
    check("bit_offset", 32'(bit_offset), 32'(m_off));
  endtask

  task automatic check_zero();
    check("rst_data",   32'(data),       32'd0);
    check("rst_ctrl",   32'(ctrl),       32'd0);
    check("rst_de",     32'(de),         32'd0);
    check("rst_locked", 32'(locked),     32'd0);
    check("rst_offset", 32'(bit_offset), 32'd0);
  endtask

  task automatic cycle(input logic [9:0] w);
    tmds_word = w;
    model_step(w);
    @(posedge pixclk);
    #1;
    check_model();
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic lock_sequence();
    for (int i = 1; i <= 16; i++) begin
      cycle(T00);
      if (i == 10) check("pre_lock", 32'(locked), 32'd0);
      if (i == 11) check("lock_edge", 32'(locked), 32'd1);
    end
    check("locked", 32'(locked), 32'd1);
    check("de", 32'(de), 32'd0);
    check("ctrl", 32'(ctrl), 32'd0);
    check("offset", 32'(bit_offset), 32'd0);
  endtask

  // Data word with at most two internal transitions, so no window spanning
  // data words (or a data/token boundary) can look like a control token.
  function automatic logic [9:0] quiet_word();
    int a, b;
    logic [9:0] w;
    a = $urandom_range(0, 10);
    b = $urandom_range(a, 10);
    w = 10'((32'd1 << b) - (32'd1 << a));
    if ($urandom_range(0, 1) == 1) w = ~w;
    return w;
  endfunction

  initial begin
    bit s[$];
    logic [9:0] w;
    int lock_cycle;
    int n;

    model_reset();
    #1;
    rst_n = 1'b0;
    #2;
    phase = "reset";
    check_zero();
    #9;
    rst_n = 1'b1;

    phase = "lock0";
    lock_sequence();

    phase = "data";
    cycle(WA);
    cycle(WB);
    cycle(T00);
    cycle(T00);
    check("de_a", 32'(de), 32'd1);
    check("data_a", 32'(data), 32'h00);
    cycle(T00);
    check("data_b", 32'(data), 32'hFE);
    cycle(T00);
    check("de_tok", 32'(de), 32'd0);

    phase = "ctrl";
    cycle(T11);
    cycle(T01);
    cycle(T00);
    cycle(T00);
    check("ctrl11", 32'(ctrl), 32'd3);
    check("de11", 32'(de), 32'd0);
    cycle(T00);
    check("ctrl01", 32'(ctrl), 32'd1);

    phase = "random";
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: w = T00;
        1: w = T01;
        2: w = T10;
        3: w = T11;
        default: w = 10'($urandom);
      endcase
      cycle(w);
    end
    for (int i = 0; i < 4; i++) cycle(T00);

    phase = "loss";
    for (int i = 1; i <= 3076; i++) begin
      cycle(WA);
      if (i == 2050) check("still_locked", 32'(locked), 32'd1);
      if (i == 2051) begin
        check("dropped", 32'(locked), 32'd0);
        check("de_forced", 32'(de), 32'd0);
      end
      if (i == 3074) check("offset_hold", 32'(bit_offset), 32'd0);
      if (i == 3075) check("offset_adv", 32'(bit_offset), 32'd1);
    end

    phase = "rot3";
    async_reset();
    for (int i = 0; i < 3; i++) s.push_back(1'b0);
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 160; k++)
        for (int i = 0; i < 10; i++) s.push_back(T00[i]);
      for (int k = 0; k < 640; k++) begin
        w = quiet_word();
        for (int i = 0; i < 10; i++) s.push_back(w[i]);
      end
    end
    lock_cycle = -1;
    n = 0;
    for (int idx = 0; idx + 10 <= s.size(); idx += 10) begin
      for (int i = 0; i < 10; i++) w[i] = s[idx + i];
      cycle(w);
      n++;
      if (lock_cycle < 0 && locked === 1'b1) lock_cycle = n;
    end
    check("lock_time", 32'(lock_cycle >= 0 && lock_cycle <= 10 * SEARCH_TIMEOUT), 32'd1);
    check("locked", 32'(locked), 32'd1);
    check("offset3", 32'(bit_offset), 32'd3);

    phase = "rst_mid";
    async_reset();
    lock_sequence();
    async_reset();
    phase = "relock";
    lock_sequence();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
